// File: rtl/pc_unit.sv
// pc_unit: 16-bit SM83 program counter.
//
// Holds PC and drives it onto the shared address bus. It supports:
//   - a two-phase increment: tap PC+1, then commit it;
//   - a load from the address bus;
//   - a staged 16-bit immediate load (JP a16);
//   - a signed relative add (JR e8).
//
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   addr_bus       - shared tri-state bus; PC is driven while pc_oe=1
//   data_bus       - memory read data (staging bytes / relative offset)
//   pc_oe          - drive PC onto addr_bus (combinational)
//   pc_wr          - commit a PC write; the source is selected by pc_inc_en
//   pc_ldl/pc_ldh  - capture data_bus into the low/high staging byte
//   pc_ld16        - PC <= {high stage, low stage}, with same-cycle bypass
//   pc_inc_en      - with pc_wr, commit PC from the increment tap
//   pc_inc_tap_en  - capture PC+1 into the tap register
//   pc_rel_en      - PC <= PC + sign-extended data_bus
//   pc_value       - current PC
//   pc_tap_valid   - tap holds PC+1 of the current PC
module pc_unit #(
  parameter logic [15:0] RESET_VEC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] addr_bus,
  input  logic [7:0]  data_bus,
  input  logic        pc_oe,
  input  logic        pc_wr,
  input  logic        pc_ldl,
  input  logic        pc_ldh,
  input  logic        pc_ld16,
  input  logic        pc_inc_en,
  input  logic        pc_inc_tap_en,
  input  logic        pc_rel_en,
  output logic [15:0] pc_value,
  output logic        pc_tap_valid
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] tap_q, tap_d;
  logic [7:0]  stage_l_q, stage_l_d;
  logic [7:0]  stage_h_q, stage_h_d;
  logic        tap_vld_q, tap_vld_d;
  logic        pc_we;

  logic [15:0] pc_plus1;
  logic [15:0] rel_off;
  logic [7:0]  ld_lo, ld_hi;

  assign pc_plus1 = pc_q + 16'd1;
  assign rel_off  = {{8{data_bus[7]}}, data_bus};

  // A byte captured in the same cycle as pc_ld16 bypasses its stage register.
  // This lets the last operand byte and the jump share one cycle.
  assign ld_lo = pc_ldl ? data_bus : stage_l_q;
  assign ld_hi = pc_ldh ? data_bus : stage_h_q;

  assign addr_bus     = pc_oe ? pc_q : 16'hzzzz;
  assign pc_value     = pc_q;
  assign pc_tap_valid = tap_vld_q;

  always_comb begin
    pc_d  = pc_q;
    pc_we = 1'b0;
    if (pc_ld16) begin
      pc_d  = {ld_hi, ld_lo};
      pc_we = 1'b1;
    end else if (pc_rel_en) begin
      pc_d  = pc_q + rel_off;
      pc_we = 1'b1;
    end else if (pc_wr && pc_inc_en) begin
      // Without a prior tap, fall back to a direct one-cycle increment.
      pc_d  = tap_vld_q ? tap_q : pc_plus1;
      pc_we = 1'b1;
    end else if (pc_wr && !pc_oe) begin
      pc_d  = addr_bus;
      pc_we = 1'b1;
    end
    // pc_wr with pc_oe and no increment would just read PC back: treat as a no-op.
  end

  always_comb begin
    tap_d     = pc_inc_tap_en ? pc_plus1 : tap_q;
    stage_l_d = pc_ldl ? data_bus : stage_l_q;
    stage_h_d = pc_ldh ? data_bus : stage_h_q;
    // A tap taken alongside a write refers to the old PC, so it is never valid.
    if (pc_we)              tap_vld_d = 1'b0;
    else if (pc_inc_tap_en) tap_vld_d = 1'b1;
    else                    tap_vld_d = tap_vld_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_VEC;
      tap_q     <= 16'h0000;
      stage_l_q <= 8'h00;
      stage_h_q <= 8'h00;
      tap_vld_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      tap_q     <= tap_d;
      stage_l_q <= stage_l_d;
      stage_h_q <= stage_h_d;
      tap_vld_q <= tap_vld_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and random stimulus for pc_unit.
// Results are checked against an arithmetic reference model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] addr_bus;
  logic [7:0]  data_bus;
  logic        pc_oe, pc_wr, pc_ldl, pc_ldh, pc_ld16;
  logic        pc_inc_en, pc_inc_tap_en, pc_rel_en;
  logic [15:0] pc_value;
  logic        pc_tap_valid;
  logic [15:0] ext_val;

  // The external driver owns the bus whenever the PC is not driving it.
  assign addr_bus = pc_oe ? 16'hzzzz : ext_val;

  pc_unit #(.RESET_VEC(16'h0000)) dut (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus(data_bus),
    .pc_oe(pc_oe), .pc_wr(pc_wr), .pc_ldl(pc_ldl), .pc_ldh(pc_ldh),
    .pc_ld16(pc_ld16), .pc_inc_en(pc_inc_en), .pc_inc_tap_en(pc_inc_tap_en),
    .pc_rel_en(pc_rel_en), .pc_value(pc_value), .pc_tap_valid(pc_tap_valid)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state, kept as plain integers.
  int m_pc, m_tap, m_sl, m_sh;
  bit m_valid;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, oe, wr, inc, tap, rel, ldl, ldh, ld16,
                       input int d, input int ext);
    int  nxt, lo, hi, off;
    bit  wrote;
    if (r) begin
      m_pc = 0; m_tap = 0; m_sl = 0; m_sh = 0; m_valid = 0;
      return;
    end
    lo    = ldl ? d : m_sl;
    hi    = ldh ? d : m_sh;
    off   = (d >= 128) ? d - 256 : d;
    wrote = 1;
    nxt   = m_pc;
    if (ld16)              nxt = hi * 256 + lo;
    else if (rel)          nxt = (m_pc + off + 65536) % 65536;
    else if (wr && inc)    nxt = m_valid ? m_tap : (m_pc + 1) % 65536;
    else if (wr && !oe)    nxt = ext;
    else                   wrote = 0;
    if (tap) m_tap = (m_pc + 1) % 65536;
    m_valid = wrote ? 1'b0 : (tap ? 1'b1 : m_valid);
    if (ldl) m_sl = d;
    if (ldh) m_sh = d;
    m_pc = nxt;
  endtask

  // Apply one cycle of strobes, check the bus before the edge and the state after it.
  task automatic step(input bit r, oe, wr, inc, tap, rel, ldl, ldh, ld16,
                      input logic [7:0] d, input logic [15:0] ext);
    rst = r; pc_oe = oe; pc_wr = wr; pc_inc_en = inc; pc_inc_tap_en = tap;
    pc_rel_en = rel; pc_ldl = ldl; pc_ldh = ldh; pc_ld16 = ld16;
    data_bus = d; ext_val = ext;
    #1;
    if (oe) chk("addr_bus", addr_bus, m_pc[15:0]);
    @(posedge clk);
    model(r, oe, wr, inc, tap, rel, ldl, ldh, ld16, int'(d), int'(ext));
    #1;
    chk("pc_value", pc_value, m_pc[15:0]);
    chk("pc_tap_valid", {15'd0, pc_tap_valid}, {15'd0, m_valid});
  endtask

  //                       r  oe wr inc tap rel ldl ldh ld16 data  ext
  initial begin
    m_pc = 0; m_tap = 0; m_sl = 0; m_sh = 0; m_valid = 0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
    chk("reset_pc", pc_value, 16'h0000);
    // Load from an external driver.
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0150);
    chk("ext_load", pc_value, 16'h0150);
    // Two-phase increment.
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0000);
    chk("tap_valid", {15'd0, pc_tap_valid}, 16'd1);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
    chk("inc_commit", pc_value, 16'h0151);
    // Wrap from FFFF to 0000.
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 16'hFFFF);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0000);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
    chk("inc_wrap", pc_value, 16'h0000);
    // Direct increment without a prior tap.
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h1234);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
    chk("inc_fallback", pc_value, 16'h1235);
    // Relative jumps.
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0200);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 8'hFE, 16'h0000);
    chk("rel_neg", pc_value, 16'h01FE);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h05, 16'h0000);
    chk("rel_pos", pc_value, 16'h0203);
    // JP sequence; ld16 outranks rel/wr.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'h34, 16'h0000);
    step(0, 0, 1, 0, 0, 1, 0, 1, 1, 8'h12, 16'h9999);
    chk("jp_bypass", pc_value, 16'h1234);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h77, 16'h0000);
    chk("jp_staged", pc_value, 16'h1234);
    // Mid-sequence reset.
    step(0, 1, 0, 0, 1, 0, 1, 0, 0, 8'hAA, 16'h0000);
    step(1, 0, 1, 1, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
    chk("rst_mid_pc", pc_value, 16'h0000);
    chk("rst_mid_vld", {15'd0, pc_tap_valid}, 16'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 16'h0000);
    chk("rst_stages", pc_value, 16'h0000);
    // Self-loopback holds the PC and leaves the tap valid.
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h4321);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0000);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
    chk("loopback_pc", pc_value, 16'h4321);
    chk("loopback_vld", {15'd0, pc_tap_valid}, 16'd1);
    // Tap and write in the same cycle: the write wins and the tap is invalid.
    step(0, 0, 1, 0, 1, 0, 0, 0, 0, 8'h00, 16'h0800);
    chk("tap_write_vld", {15'd0, pc_tap_valid}, 16'd0);
    // Random stimulus.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0,
           8'($urandom), 16'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
